// File: rtl/tick_period_meter.sv
// Tick spacing monitor: measures cycles between tick pulses, reports the recovered
// divisor and flags when LOCK_COUNT consecutive measurements agree.
module tick_period_meter #(
  parameter int unsigned WIDTH      = 17,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       LOCK_MATCH = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] last, last_nxt;
  logic [3:0]       match, match_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             period_valid_nxt;
  logic             locked_nxt;
  logic             overflow_nxt;

  // State and output registers; reset wins over any tick in the same cycle.
  always_ff @(posedge inclk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      last         <= last_nxt;
      match        <= match_nxt;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      locked       <= locked_nxt;
      overflow     <= overflow_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    last_nxt         = last;
    match_nxt        = match;
    period_nxt       = period;
    period_valid_nxt = 1'b0;
    locked_nxt       = locked;
    overflow_nxt     = overflow;

    case (state)
      IDLE: begin
        if (tick) begin
          // Reference tick: starts the interval but yields no measurement.
          cnt_nxt      = WIDTH'(1);
          match_nxt    = 4'd0;
          overflow_nxt = 1'b0;
          state_nxt    = MEASURE;
        end
      end

      default: begin
        if (tick) begin
          period_nxt       = cnt;
          last_nxt         = cnt;
          period_valid_nxt = 1'b1;
          cnt_nxt          = WIDTH'(1);
          overflow_nxt     = 1'b0;
          if (match == 4'd0 || cnt != last) begin
            match_nxt = 4'd1;
          end else if (match >= LOCK_MATCH) begin
            match_nxt = LOCK_MATCH;
          end else begin
            match_nxt = match + 4'd1;
          end
          locked_nxt = (match_nxt == LOCK_MATCH);
          state_nxt  = locked_nxt ? LOCKED : MEASURE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + WIDTH'(1);
        end else begin
          // Saturated without a tick: drop the reference and start over.
          cnt_nxt      = '0;
          overflow_nxt = 1'b1;
          locked_nxt   = 1'b0;
          match_nxt    = 4'd0;
          state_nxt    = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: a full-width and a 4-bit instance, each checked every
// cycle against a timestamp-based model, plus directed literal expectations.
module tb_tick_period_meter;

  localparam int LC = 4;

  logic        inclk = 1'b0;
  logic [1:0]  tick  = 2'b00;
  logic [1:0]  rst   = 2'b11;

  logic [16:0] period_a;
  logic        valid_a, locked_a, ovf_a;
  logic [3:0]  period_b;
  logic        valid_b, locked_b, ovf_b;

  always #5 inclk = ~inclk;

  tick_period_meter #(.WIDTH(17), .LOCK_COUNT(LC)) dut_a (
    .inclk(inclk), .reset(rst[0]), .tick(tick[0]),
    .period(period_a), .period_valid(valid_a), .locked(locked_a), .overflow(ovf_a)
  );

  tick_period_meter #(.WIDTH(4), .LOCK_COUNT(LC)) dut_b (
    .inclk(inclk), .reset(rst[1]), .tick(tick[1]),
    .period(period_b), .period_valid(valid_b), .locked(locked_b), .overflow(ovf_b)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: remembers the cycle of the last tick and a window of recent measurements.
  int  now = 0;
  int  maxv[2] = '{131071, 15};
  int  m_period[2];
  bit  m_valid[2], m_locked[2], m_ovf[2], has_ref[2];
  int  last_t[2];
  int  hist[2][LC];
  int  hist_n[2];
  bit  ready = 1'b0;

  function automatic void model_step(int i, bit tk, bit rs);
    int d;
    bit same;
    if (rs) begin
      m_period[i] = 0; m_valid[i] = 0; m_locked[i] = 0; m_ovf[i] = 0;
      has_ref[i] = 0; hist_n[i] = 0;
    end else begin
      m_valid[i] = 0;
      if (tk) begin
        if (has_ref[i]) begin
          d = now - last_t[i];
          m_period[i] = d;
          m_valid[i]  = 1;
          for (int k = 0; k < LC - 1; k++) hist[i][k] = hist[i][k+1];
          hist[i][LC-1] = d;
          if (hist_n[i] < LC) hist_n[i]++;
          same = (hist_n[i] == LC);
          for (int k = 0; k < LC; k++) if (hist[i][k] != d) same = 0;
          m_locked[i] = same;
        end
        has_ref[i] = 1;
        m_ovf[i]   = 0;
        last_t[i]  = now;
      end else if (has_ref[i] && (now - last_t[i]) >= maxv[i]) begin
        m_ovf[i] = 1; m_locked[i] = 0; has_ref[i] = 0; hist_n[i] = 0;
      end
    end
  endfunction

  always @(posedge inclk) begin
    now++;
    model_step(0, tick[0], rst[0]);
    model_step(1, tick[1], rst[1]);
    if (rst == 2'b11) ready <= 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge inclk) begin
    if (ready) begin
      chk("a_period", int'(period_a), m_period[0]);
      chk("a_valid",  int'(valid_a),  int'(m_valid[0]));
      chk("a_locked", int'(locked_a), int'(m_locked[0]));
      chk("a_ovf",    int'(ovf_a),    int'(m_ovf[0]));
      chk("b_period", int'(period_b), m_period[1]);
      chk("b_valid",  int'(valid_b),  int'(m_valid[1]));
      chk("b_locked", int'(locked_b), int'(m_locked[1]));
      chk("b_ovf",    int'(ovf_b),    int'(m_ovf[1]));
    end
  end

  task automatic clk1();
    @(posedge inclk);
    #1;
  endtask

  function automatic int out_period(int i);
    return (i == 0) ? int'(period_a) : int'(period_b);
  endfunction
  function automatic int out_valid(int i);
    return (i == 0) ? int'(valid_a) : int'(valid_b);
  endfunction
  function automatic int out_locked(int i);
    return (i == 0) ? int'(locked_a) : int'(locked_b);
  endfunction
  function automatic int out_ovf(int i);
    return (i == 0) ? int'(ovf_a) : int'(ovf_b);
  endfunction

  // One tick, literal checks on the following cycle, then gap-1 quiet cycles.
  task automatic pulse(int i, int gap, bit ev, int ep, bit el);
    tick[i] = 1'b1;
    clk1();
    chk("lit_valid",  out_valid(i),  int'(ev));
    chk("lit_locked", out_locked(i), int'(el));
    chk("lit_ovf",    out_ovf(i),    0);
    if (ev) chk("lit_period", out_period(i), ep);
    tick[i] = 1'b0;
    repeat (gap - 1) clk1();
  endtask

  task automatic do_reset(int i, bit tk);
    rst[i]  = 1'b1;
    tick[i] = tk;
    clk1();
    rst[i]  = 1'b0;
    tick[i] = 1'b0;
    chk("rst_period", out_period(i), 0);
    chk("rst_valid",  out_valid(i),  0);
    chk("rst_locked", out_locked(i), 0);
    chk("rst_ovf",    out_ovf(i),    0);
  endtask

  initial begin
    rst  = 2'b11;
    tick = 2'b00;
    repeat (2) clk1();
    rst = 2'b00;
    chk("init_period_a", int'(period_a), 0);
    chk("init_locked_b", int'(locked_b), 0);

    // Ticks every 5 cycles; lock after the fifth tick.
    for (int k = 1; k <= 10; k++) pulse(0, 5, k >= 2, 5, k >= 5);

    // One interval of 7 drops lock; four matching 5s re-acquire it.
    repeat (2) clk1();
    pulse(0, 5, 1'b1, 7, 1'b0);
    for (int k = 1; k <= 4; k++) pulse(0, 5, 1'b1, 5, k == 4);

    // Continuously high tick.
    do_reset(0, 1'b0);
    for (int k = 1; k <= 8; k++) pulse(0, 1, k >= 2, 1, k >= 5);

    // Ticks every 4 with a reset mid-interval that coincides with a tick.
    do_reset(0, 1'b0);
    for (int k = 1; k <= 3; k++) pulse(0, 4, k >= 2, 4, 1'b0);
    do_reset(0, 1'b1);
    pulse(0, 4, 1'b0, 0, 1'b0);
    pulse(0, 4, 1'b1, 4, 1'b0);

    // 4-bit instance: spacing 15 is the largest valid period, 16 overflows.
    do_reset(1, 1'b0);
    pulse(1, 15, 1'b0, 0, 1'b0);
    pulse(1, 15, 1'b1, 15, 1'b0);
    pulse(1, 16, 1'b1, 15, 1'b0);
    chk("ovf_set",     int'(ovf_b),    1);
    chk("ovf_locked",  int'(locked_b), 0);
    chk("ovf_hold",    int'(period_b), 15);
    pulse(1, 3, 1'b0, 0, 1'b0);
    pulse(1, 3, 1'b1, 3, 1'b0);
    repeat (3) clk1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
